// File: rtl/space_monsters_level_seq.sv
// Game-flow sequencer for Space Monsters: walks the level list, tracks lives and
// a saturating score, times the level intro / respawn and latches win or loss.
module space_monsters_level_seq #(
   parameter int unsigned NUM_LEVELS   = 2,
   parameter int unsigned NUM_MONSTERS = 5,
   parameter logic [NUM_LEVELS*NUM_MONSTERS-1:0] LEVEL_MASKS = 10'b11111_10101,
   parameter int unsigned LIVES        = 3,
   parameter int unsigned SCORE_W      = 8,
   parameter int unsigned INTRO_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_btn,
   input  logic [NUM_MONSTERS-1:0] monster_hit,
   input  logic                    tank_hit,
   output logic [5:0]              state,
   output logic [2:0]              level,
   output logic                    level_load,
   output logic [NUM_MONSTERS-1:0] destroyed,
   output logic [SCORE_W-1:0]      score,
   output logic [3:0]              lives,
   output logic                    game_won,
   output logic                    game_over
);

   localparam int unsigned CNT_W = (INTRO_CYCLES > 1) ? $clog2(INTRO_CYCLES) : 1;
   localparam int unsigned PC_W  = $clog2(NUM_MONSTERS + 1);
   localparam int unsigned SUM_W = SCORE_W + PC_W + 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(INTRO_CYCLES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [2:0]         LAST_LVL  = 3'(NUM_LEVELS - 1);

   typedef enum logic [5:0] {
      S_IDLE    = 6'b000001,
      S_INTRO   = 6'b000010,
      S_PLAY    = 6'b000100,
      S_RESPAWN = 6'b001000,
      S_SUCCESS = 6'b010000,
      S_FAILED  = 6'b100000
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              level_q, level_d;
   logic                    load_q, load_d;
   logic [NUM_MONSTERS-1:0] destroyed_q, destroyed_d;
   logic [SCORE_W-1:0]      score_q, score_d;
   logic [3:0]              lives_q, lives_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    won_q, won_d;
   logic                    over_q, over_d;

   logic [NUM_MONSTERS-1:0] mask_c;
   logic [NUM_MONSTERS-1:0] new_hits_c;
   logic [PC_W-1:0]         pop_c;
   logic [SUM_W-1:0]        sum_c;
   logic [SCORE_W-1:0]      score_sat_c;
   logic                    level_done_c;

   // Required-monster mask of the current level, newly scored hits and saturated score
   always_comb begin
      mask_c = '0;
      for (int k = 0; k < int'(NUM_LEVELS); k++) begin
         if (level_q == 3'(k)) mask_c = LEVEL_MASKS[k*NUM_MONSTERS +: NUM_MONSTERS];
      end
      new_hits_c = monster_hit & mask_c & ~destroyed_q;
      pop_c = '0;
      for (int i = 0; i < int'(NUM_MONSTERS); i++) begin
         pop_c = pop_c + PC_W'(new_hits_c[i]);
      end
      sum_c        = SUM_W'(score_q) + SUM_W'(pop_c);
      score_sat_c  = (sum_c > SUM_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(sum_c);
      level_done_c = ((destroyed_q | new_hits_c) & mask_c) == mask_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         level_q     <= '0;
         load_q      <= 1'b0;
         destroyed_q <= '0;
         score_q     <= '0;
         lives_q     <= 4'(LIVES);
         cnt_q       <= '0;
         won_q       <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         load_q      <= load_d;
         destroyed_q <= destroyed_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         cnt_q       <= cnt_d;
         won_q       <= won_d;
         over_q      <= over_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      load_d      = 1'b0;
      destroyed_d = destroyed_q;
      score_d     = score_q;
      lives_d     = lives_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_btn) begin
               score_d     = '0;
               destroyed_d = '0;
               lives_d     = 4'(LIVES);
               level_d     = '0;
               cnt_d       = CNT_LOAD;
               load_d      = 1'b1;
               state_d     = S_INTRO;
            end
         end
         S_INTRO, S_RESPAWN: begin
            if (cnt_q == '0) state_d = S_PLAY;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_PLAY: begin
            destroyed_d = destroyed_q | new_hits_c;
            score_d     = score_sat_c;
            // Completion takes priority over a same-cycle tank hit
            if (level_done_c) begin
               if (level_q == LAST_LVL) begin
                  state_d = S_SUCCESS;
               end else begin
                  level_d     = level_q + 3'd1;
                  destroyed_d = '0;
                  cnt_d       = CNT_LOAD;
                  load_d      = 1'b1;
                  state_d     = S_INTRO;
               end
            end else if (tank_hit) begin
               lives_d = lives_q - 4'd1;
               if (lives_q == 4'd1) begin
                  state_d = S_FAILED;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = S_RESPAWN;
               end
            end
         end
         S_SUCCESS, S_FAILED: begin
            if (start_btn) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      won_d  = (state_d == S_SUCCESS);
      over_d = (state_d == S_FAILED);
   end

   assign state      = state_q;
   assign level      = level_q;
   assign level_load = load_q;
   assign destroyed  = destroyed_q;
   assign score      = score_q;
   assign lives      = lives_q;
   assign game_won   = won_q;
   assign game_over  = over_q;

endmodule

// File: tb/tb_space_monsters_level_seq.sv
// Bench for space_monsters_level_seq: directed game scenarios followed by random play,
// every cycle compared against a game-rule model (8-bit and 2-bit score instances).
module tb_space_monsters_level_seq;

   localparam int unsigned NL    = 2;
   localparam int unsigned NM    = 5;
   localparam logic [9:0]  MASKS = 10'b11111_10101;
   localparam int unsigned LV    = 3;
   localparam int unsigned INTRO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_btn;
   logic [4:0] monster_hit;
   logic       tank_hit;

   logic [5:0] state,  s_state;
   logic [2:0] level,  s_level;
   logic       level_load, s_load;
   logic [4:0] destroyed,  s_destroyed;
   logic [7:0] score;
   logic [1:0] s_score;
   logic [3:0] lives,  s_lives;
   logic       game_won,  s_won;
   logic       game_over, s_over;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   space_monsters_level_seq #(
      .NUM_LEVELS(NL), .NUM_MONSTERS(NM), .LEVEL_MASKS(MASKS),
      .LIVES(LV), .SCORE_W(8), .INTRO_CYCLES(INTRO)
   ) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn), .monster_hit(monster_hit),
      .tank_hit(tank_hit), .state(state), .level(level), .level_load(level_load),
      .destroyed(destroyed), .score(score), .lives(lives),
      .game_won(game_won), .game_over(game_over)
   );

   space_monsters_level_seq #(
      .NUM_LEVELS(NL), .NUM_MONSTERS(NM), .LEVEL_MASKS(MASKS),
      .LIVES(LV), .SCORE_W(2), .INTRO_CYCLES(INTRO)
   ) dut_sat (
      .clk(clk), .rst(rst), .start_btn(start_btn), .monster_hit(monster_hit),
      .tank_hit(tank_hit), .state(s_state), .level(s_level), .level_load(s_load),
      .destroyed(s_destroyed), .score(s_score), .lives(s_lives),
      .game_won(s_won), .game_over(s_over)
   );

   // Game-rule model: phase name, cycles left in the timed phase, raw kill count
   typedef enum int {M_IDLE = 0, M_INTRO = 1, M_PLAY = 2, M_RESPAWN = 3,
                     M_SUCCESS = 4, M_FAILED = 5} phase_t;
   phase_t     m_st;
   int         m_level, m_kills, m_lives, m_timer;
   bit         m_load;
   logic [4:0] m_destroyed;

   function automatic logic [4:0] level_mask(input int lvl);
      logic [9:0] all;
      all = MASKS;
      return all[lvl*5 +: 5];
   endfunction

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_level = 0; m_kills = 0; m_lives = LV;
      m_timer = 0; m_load = 0; m_destroyed = '0;
   endtask

   task automatic model_step(input logic sb, input logic [4:0] mh, input logic th);
      logic [4:0] req, fresh;
      m_load = 0;
      case (m_st)
         M_IDLE: if (sb) begin
            m_kills = 0; m_destroyed = '0; m_lives = LV; m_level = 0;
            m_st = M_INTRO; m_timer = INTRO; m_load = 1;
         end
         M_INTRO, M_RESPAWN: begin
            m_timer--;
            if (m_timer == 0) m_st = M_PLAY;
         end
         M_PLAY: begin
            req   = level_mask(m_level);
            fresh = mh & req & ~m_destroyed;
            m_destroyed = m_destroyed | fresh;
            m_kills += $countones(fresh);
            if ((m_destroyed & req) == req) begin
               if (m_level == NL - 1) m_st = M_SUCCESS;
               else begin
                  m_level++; m_destroyed = '0;
                  m_st = M_INTRO; m_timer = INTRO; m_load = 1;
               end
            end else if (th) begin
               m_lives--;
               if (m_lives == 0) m_st = M_FAILED;
               else begin m_st = M_RESPAWN; m_timer = INTRO; end
            end
         end
         default: if (sb) m_st = M_IDLE;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [5:0] es;
      es = 6'(1) << int'(m_st);
      chk("state",      32'(state),      32'(es));
      chk("level",      32'(level),      32'(m_level));
      chk("level_load", 32'(level_load), 32'(m_load));
      chk("destroyed",  32'(destroyed),  32'(m_destroyed));
      chk("score",      32'(score),      32'(min_i(m_kills, 255)));
      chk("lives",      32'(lives),      32'(m_lives));
      chk("game_won",   32'(game_won),   32'(m_st == M_SUCCESS));
      chk("game_over",  32'(game_over),  32'(m_st == M_FAILED));
      chk("sat_state",  32'(s_state),    32'(es));
      chk("sat_level",  32'(s_level),    32'(m_level));
      chk("sat_load",   32'(s_load),     32'(m_load));
      chk("sat_destr",  32'(s_destroyed), 32'(m_destroyed));
      chk("sat_score",  32'(s_score),    32'(min_i(m_kills, 3)));
      chk("sat_lives",  32'(s_lives),    32'(m_lives));
      chk("sat_won",    32'(s_won),      32'(m_st == M_SUCCESS));
      chk("sat_over",   32'(s_over),     32'(m_st == M_FAILED));
   endtask

   task automatic cycle(input logic sb, input logic [4:0] mh, input logic th);
      start_btn = sb; monster_hit = mh; tank_hit = th;
      @(posedge clk);
      model_step(sb, mh, th);
      #1;
      start_btn = 1'b0; monster_hit = '0; tank_hit = 1'b0;
      check_all();
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      model_reset();
      #1 check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start_btn = 1'b0; monster_hit = '0; tank_hit = 1'b0;
      model_reset();
      #2 check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      check_all();

      // Game 1: start, intro timing, level 0 then level 1 to SUCCESS
      cycle(1, 5'b0, 0);
      chk("start_load", 32'(level_load), 32'd1);
      chk("start_intro", 32'(state), 32'h02);
      cycle(0, 5'b00001, 1);
      cycle(0, 5'b0, 0);
      cycle(0, 5'b0, 0);
      chk("intro_4th", 32'(state), 32'h02);
      cycle(0, 5'b0, 0);
      chk("play_entry", 32'(state), 32'h04);
      chk("play_lives", 32'(lives), 32'd3);
      cycle(0, 5'b00001, 0);
      cycle(1, 5'b00010, 0);
      cycle(0, 5'b00100, 0);
      cycle(0, 5'b00100, 0);
      chk("repeat_score", 32'(score), 32'd2);
      chk("l0_destroyed", 32'(destroyed), 32'h05);
      cycle(0, 5'b10000, 0);
      chk("l0_score", 32'(score), 32'd3);
      chk("l1_level", 32'(level), 32'd1);
      chk("l1_load", 32'(level_load), 32'd1);
      chk("l1_destr", 32'(destroyed), 32'd0);
      repeat (4) cycle(0, 5'b0, 0);
      cycle(0, 5'b11111, 0);
      chk("win_score", 32'(score), 32'd8);
      chk("win_state", 32'(state), 32'h10);
      chk("win_flag", 32'(game_won), 32'd1);
      chk("sat_score3", 32'(s_score), 32'd3);
      cycle(0, 5'b11111, 1);
      cycle(1, 5'b0, 0);
      chk("back_idle", 32'(state), 32'h01);
      chk("idle_score", 32'(score), 32'd8);

      // Game 2: three tank hits with respawns, ending in FAILED
      cycle(1, 5'b0, 0);
      repeat (4) cycle(0, 5'b0, 0);
      cycle(0, 5'b00001, 0);
      cycle(0, 5'b0, 1);
      chk("tank1_lives", 32'(lives), 32'd2);
      chk("tank1_state", 32'(state), 32'h08);
      chk("tank1_destr", 32'(destroyed), 32'h01);
      repeat (3) cycle(1, 5'b00100, 1);
      chk("respawn_4th", 32'(state), 32'h08);
      cycle(0, 5'b0, 0);
      chk("respawn_end", 32'(state), 32'h04);
      cycle(0, 5'b0, 1);
      chk("tank2_lives", 32'(lives), 32'd1);
      repeat (4) cycle(0, 5'b0, 0);
      cycle(0, 5'b0, 1);
      chk("tank3_lives", 32'(lives), 32'd0);
      chk("fail_flag", 32'(game_over), 32'd1);
      cycle(0, 5'b10101, 1);
      cycle(1, 5'b0, 0);
      chk("idle_lives", 32'(lives), 32'd0);

      // Game 3: completing hit and tank hit in the same cycle, then async reset in PLAY
      cycle(1, 5'b0, 0);
      repeat (4) cycle(0, 5'b0, 0);
      cycle(0, 5'b10001, 0);
      chk("pre_destr", 32'(destroyed), 32'h11);
      cycle(0, 5'b00100, 1);
      chk("tie_state", 32'(state), 32'h02);
      chk("tie_lives", 32'(lives), 32'd3);
      chk("tie_score", 32'(score), 32'd3);
      repeat (4) cycle(0, 5'b0, 0);
      cycle(0, 5'b00011, 0);
      async_reset();
      chk("rst_state", 32'(state), 32'h01);
      chk("rst_score", 32'(score), 32'd0);

      // Random play with occasional mid-game resets
      for (int n = 0; n < 900; n++) begin
         logic [4:0] mh;
         for (int b = 0; b < 5; b++) mh[b] = ($urandom_range(0, 3) == 0);
         cycle(logic'($urandom_range(0, 15) == 0), mh, logic'($urandom_range(0, 11) == 0));
         if ($urandom_range(0, 199) == 0) async_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
